// File: rtl/issue_arbiter.sv
// Dual-ALU issue arbiter for the reservation station.
// Grants up to two ready entries per cycle, one to each ALU. The search is
// round-robin from rr_ptr. An entry that has waited STARVE_LIMIT cycles
// takes slot A ahead of the round-robin order. All outputs are registered.
module issue_arbiter #(
  parameter int ENTRIES      = 8,
  parameter int IDX_W        = 3,
  parameter int STARVE_LIMIT = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic [ENTRIES-1:0] ready,
  input  logic               alu1_free,
  input  logic               alu2_free,
  output logic               issue1_valid,
  output logic [IDX_W-1:0]   issue1_idx,
  output logic               issue2_valid,
  output logic [IDX_W-1:0]   issue2_idx,
  output logic [ENTRIES-1:0] issue_onehot,
  output logic [IDX_W-1:0]   rr_ptr,
  output logic               starve_flag
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0]   wait_cnt [ENTRIES];
  logic [ENTRIES-1:0] cand;
  logic [ENTRIES-1:0] starved;
  logic               force_any;
  logic [IDX_W-1:0]   force_idx;
  logic               hit1, hit2;
  logic [IDX_W-1:0]   scan1, scan2;
  logic               a_v, b_v;
  logic [IDX_W-1:0]   a_idx, b_idx;
  logic               g1_v, g2_v;
  logic [IDX_W-1:0]   g1_idx, g2_idx;
  logic [ENTRIES-1:0] grant_vec;
  logic [IDX_W-1:0]   rr_next;
  logic               starve_next;

  // Distance of an index from the current round-robin start, in scan order
  function automatic int scan_offset(input logic [IDX_W-1:0] idx,
                                     input logic [IDX_W-1:0] start);
    return (int'(idx) + ENTRIES - int'(start)) % ENTRIES;
  endfunction

  // Entries granted last cycle are still leaving the station, so mask them out
  assign cand = ready & ~issue_onehot;

  // Find starved candidates; the lowest index wins the forced slot
  always_comb begin
    starved   = '0;
    force_any = 1'b0;
    force_idx = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      starved[i] = cand[i] && (wait_cnt[i] == CNT_MAX);
    end
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (starved[i]) begin
        force_any = 1'b1;
        force_idx = IDX_W'(i);
      end
    end
  end

  // Round-robin scan for the first two candidates, skipping any forced entry
  always_comb begin
    int p;
    p     = 0;
    hit1  = 1'b0;
    hit2  = 1'b0;
    scan1 = '0;
    scan2 = '0;
    for (int k = 0; k < ENTRIES; k++) begin
      p = (int'(rr_ptr) + k) % ENTRIES;
      if (cand[p] && !(force_any && (IDX_W'(p) == force_idx))) begin
        if (!hit1) begin
          hit1  = 1'b1;
          scan1 = IDX_W'(p);
        end else if (!hit2) begin
          hit2  = 1'b1;
          scan2 = IDX_W'(p);
        end
      end
    end
  end

  // Build slots A/B, map them onto the free ALUs, and work out the next pointer
  always_comb begin
    int max_off;
    a_v         = hit1;
    a_idx       = scan1;
    b_v         = hit2;
    b_idx       = scan2;
    g1_v        = 1'b0;
    g1_idx      = '0;
    g2_v        = 1'b0;
    g2_idx      = '0;
    grant_vec   = '0;
    max_off     = 0;
    rr_next     = rr_ptr;
    starve_next = 1'b0;

    if (force_any) begin
      a_v   = 1'b1;
      a_idx = force_idx;
      b_v   = hit1;
      b_idx = scan1;
    end

    if (alu1_free) begin
      g1_v   = a_v;
      g1_idx = a_v ? a_idx : '0;
      if (alu2_free) begin
        g2_v   = b_v;
        g2_idx = b_v ? b_idx : '0;
      end
    end else if (alu2_free) begin
      g2_v   = a_v;
      g2_idx = a_v ? a_idx : '0;
    end

    if (g1_v) begin
      grant_vec[g1_idx] = 1'b1;
      max_off = scan_offset(g1_idx, rr_ptr);
    end
    if (g2_v) begin
      grant_vec[g2_idx] = 1'b1;
      if (scan_offset(g2_idx, rr_ptr) > max_off) begin
        max_off = scan_offset(g2_idx, rr_ptr);
      end
    end
    if (g1_v || g2_v) begin
      rr_next = IDX_W'((int'(rr_ptr) + max_off + 1) % ENTRIES);
    end

    starve_next = force_any && (alu1_free || alu2_free);
  end

  // Register grants, pointer and wait counters; reset and flush clear everything
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      issue1_valid <= 1'b0;
      issue1_idx   <= '0;
      issue2_valid <= 1'b0;
      issue2_idx   <= '0;
      issue_onehot <= '0;
      rr_ptr       <= '0;
      starve_flag  <= 1'b0;
      for (int i = 0; i < ENTRIES; i++) begin
        wait_cnt[i] <= '0;
      end
    end else begin
      issue1_valid <= g1_v;
      issue1_idx   <= g1_idx;
      issue2_valid <= g2_v;
      issue2_idx   <= g2_idx;
      issue_onehot <= grant_vec;
      rr_ptr       <= rr_next;
      starve_flag  <= starve_next;
      for (int i = 0; i < ENTRIES; i++) begin
        if (!ready[i] || grant_vec[i]) begin
          wait_cnt[i] <= '0;
        end else if (cand[i] && (wait_cnt[i] != CNT_MAX)) begin
          wait_cnt[i] <= wait_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_issue_arbiter.sv
// Directed testbench for issue_arbiter.
// applyStimulus drives a step and pushes the expected result onto a
// scoreboard queue. checkOutput pops that entry and compares it against the
// registered outputs one cycle later.
module tb_issue_arbiter;

  logic       clk;
  logic       rst;
  logic       flush;
  logic [7:0] ready;
  logic       alu1_free;
  logic       alu2_free;
  logic       issue1_valid;
  logic [2:0] issue1_idx;
  logic       issue2_valid;
  logic [2:0] issue2_idx;
  logic [7:0] issue_onehot;
  logic [2:0] rr_ptr;
  logic       starve_flag;

  typedef struct {
    string      tag;
    logic       i1v;
    logic [2:0] i1;
    logic       i2v;
    logic [2:0] i2;
    logic [7:0] oh;
    logic [2:0] rr;
    logic       sf;
  } exp_t;

  exp_t sb[$];
  int   assert_count;
  int   fail_count;

  issue_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .ready        (ready),
    .alu1_free    (alu1_free),
    .alu2_free    (alu2_free),
    .issue1_valid (issue1_valid),
    .issue1_idx   (issue1_idx),
    .issue2_valid (issue2_valid),
    .issue2_idx   (issue2_idx),
    .issue_onehot (issue_onehot),
    .rr_ptr       (rr_ptr),
    .starve_flag  (starve_flag)
  );

  // Free-running clock with a 10 ns period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so the run always ends
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] simulation timeout");
  end

  task automatic checkValue(input string tag, input string field,
                            input logic [7:0] obs, input logic [7:0] exp);
    assert_count++;
    assert (obs === exp) else begin
      fail_count++;
      $error("[TB] FAIL %s.%s: observed %h expected %h", tag, field, obs, exp);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    assert_count++;
    assert (sb.size() > 0) else begin
      fail_count++;
      $error("[TB] FAIL scoreboard: observed empty queue, expected an entry");
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checkValue(e.tag, "issue1_valid", 8'(issue1_valid), 8'(e.i1v));
      checkValue(e.tag, "issue1_idx",   8'(issue1_idx),   8'(e.i1));
      checkValue(e.tag, "issue2_valid", 8'(issue2_valid), 8'(e.i2v));
      checkValue(e.tag, "issue2_idx",   8'(issue2_idx),   8'(e.i2));
      checkValue(e.tag, "issue_onehot", issue_onehot,     e.oh);
      checkValue(e.tag, "rr_ptr",       8'(rr_ptr),       8'(e.rr));
      checkValue(e.tag, "starve_flag",  8'(starve_flag),  8'(e.sf));
    end
  endtask

  task automatic applyStimulus(input string tag, input logic r, input logic f,
                               input logic [7:0] rd, input logic a1, input logic a2,
                               input logic e_i1v, input logic [2:0] e_i1,
                               input logic e_i2v, input logic [2:0] e_i2,
                               input logic [7:0] e_oh, input logic [2:0] e_rr,
                               input logic e_sf);
    exp_t e;
    @(negedge clk);
    rst       = r;
    flush     = f;
    ready     = rd;
    alu1_free = a1;
    alu2_free = a2;
    e.tag = tag;
    e.i1v = e_i1v;
    e.i1  = e_i1;
    e.i2v = e_i2v;
    e.i2  = e_i2;
    e.oh  = e_oh;
    e.rr  = e_rr;
    e.sf  = e_sf;
    sb.push_back(e);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  // Directed sequence: reset, round-robin, wrap, masking, single-ALU, flush, starvation
  initial begin
    assert_count = 0;
    fail_count   = 0;
    rst = 1'b1; flush = 1'b0; ready = '0; alu1_free = 1'b0; alu2_free = 1'b0;

    applyStimulus("reset",      1, 0, 8'hFF, 1, 1, 0, 0, 0, 0, 8'h00, 0, 0);
    applyStimulus("first",      0, 0, 8'h06, 1, 1, 1, 1, 1, 2, 8'h06, 3, 0);
    applyStimulus("idle",       0, 0, 8'h00, 1, 1, 0, 0, 0, 0, 8'h00, 3, 0);
    applyStimulus("to_six",     0, 0, 8'h20, 1, 0, 1, 5, 0, 0, 8'h20, 6, 0);
    applyStimulus("wrap",       0, 0, 8'hC1, 1, 1, 1, 6, 1, 7, 8'hC0, 0, 0);
    applyStimulus("masked",     0, 0, 8'hC1, 1, 1, 1, 0, 0, 0, 8'h01, 1, 0);
    applyStimulus("flush",      0, 1, 8'hFF, 1, 1, 0, 0, 0, 0, 8'h00, 0, 0);
    applyStimulus("alu2_only",  0, 0, 8'h03, 0, 1, 0, 0, 1, 0, 8'h01, 1, 0);
    checkValue("alu2_only", "wait_cnt1", 8'(dut.wait_cnt[1]), 8'd1);
    checkValue("alu2_only", "wait_cnt0", 8'(dut.wait_cnt[0]), 8'd0);

    applyStimulus("flush2",     0, 1, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus("busy",     0, 0, 8'h20, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0);
    end
    checkValue("busy", "wait_cnt5", 8'(dut.wait_cnt[5]), 8'd7);

    applyStimulus("starve",     0, 0, 8'h3F, 1, 0, 1, 5, 0, 0, 8'h20, 6, 1);
    applyStimulus("after_starve", 0, 0, 8'h3F, 1, 1, 1, 0, 1, 1, 8'h03, 2, 0);
    applyStimulus("none_ready", 0, 0, 8'h00, 1, 1, 0, 0, 0, 0, 8'h00, 2, 0);
    applyStimulus("rst_flush",  1, 1, 8'hFF, 1, 1, 0, 0, 0, 0, 8'h00, 0, 0);
    applyStimulus("post_rst",   0, 0, 8'hFF, 1, 1, 1, 0, 1, 1, 8'h03, 2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
